// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch/decode front end:
//     - opclass_t     : decoded instruction class carried to dispatch
//     - OPC_*         : RV32I major opcode values (inst[6:0])
//     - dec_fields_t  : decoded-instruction bundle (class, registers, immediate)
//     - sext12        : sign-extends a 12-bit immediate to 32 bits
//   No ports; imported by rv32_decoder and dispatch_decode.
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [3:0] {
        OC_ALU     = 4'd0,
        OC_ALUI    = 4'd1,
        OC_LOAD    = 4'd2,
        OC_STORE   = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_JAL     = 4'd5,
        OC_JALR    = 4'd6,
        OC_LUI     = 4'd7,
        OC_AUIPC   = 4'd8,
        OC_ILLEGAL = 4'd15
    } opclass_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        opclass_t    opclass;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_fields_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32_decoder.sv
// ----------------------------------------------------------------------------
// rv32_decoder
//   Purely combinational RV32I field decoder. Classifies the instruction by
//   its major opcode and extracts the register fields and the sign-extended
//   immediate of the matching format. Register fields not used by the format
//   are forced to 0; R-type has imm 0. Unknown opcodes decode as OC_ILLEGAL
//   with every field 0.
//
//   Ports:
//     inst     in   32  instruction word
//     opclass  out  4   opclass_t value
//     rd       out  5   destination register (0 if unused)
//     rs1      out  5   source register 1 (0 if unused)
//     rs2      out  5   source register 2 (0 if unused)
//     imm      out  32  sign-extended immediate (0 if none)
// ----------------------------------------------------------------------------
module rv32_decoder
    import fetch_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  opclass,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm
);

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    opclass_t    oc;

    assign opcode = inst[6:0];

    assign imm_i = sext12(inst[31:20]);
    assign imm_s = sext12({inst[31:25], inst[11:7]});
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        oc  = OC_ILLEGAL;
        rd  = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        imm = 32'd0;
        case (opcode)
            OPC_OP: begin
                oc  = OC_ALU;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                rs2 = inst[24:20];
            end
            OPC_OP_IMM: begin
                oc  = OC_ALUI;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = imm_i;
            end
            OPC_LOAD: begin
                oc  = OC_LOAD;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = imm_i;
            end
            OPC_JALR: begin
                oc  = OC_JALR;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = imm_i;
            end
            OPC_STORE: begin
                oc  = OC_STORE;
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = imm_s;
            end
            OPC_BRANCH: begin
                oc  = OC_BRANCH;
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = imm_b;
            end
            OPC_LUI: begin
                oc  = OC_LUI;
                rd  = inst[11:7];
                imm = imm_u;
            end
            OPC_AUIPC: begin
                oc  = OC_AUIPC;
                rd  = inst[11:7];
                imm = imm_u;
            end
            OPC_JAL: begin
                oc  = OC_JAL;
                rd  = inst[11:7];
                imm = imm_j;
            end
            default: begin
                oc = OC_ILLEGAL;
            end
        endcase
    end

    assign opclass = oc;

endmodule

// File: rtl/dispatch_decode.sv
// ----------------------------------------------------------------------------
// dispatch_decode
//   Decode stage between the instruction fetch queue (IFQ) and dispatch.
//   Pops one instruction per cycle from the first-word-fall-through IFQ head,
//   decodes it into a registered output slot, resolves JAL targets locally and
//   redirects the IFQ. Execute-stage redirects are forwarded to the IFQ and
//   squash the slot. After any redirect, popping is suppressed for FLUSH_CYC
//   cycles so wrong-path entries still at the IFQ head are not consumed.
//
//   Optional build macro: DISPATCH_DECODE_STATS_EN adds wrapping statistic
//   counters as extra output ports (stat_*). Without it those ports do not
//   exist and the functional behaviour is unchanged.
//
//   Parameters:
//     PC_W       PC / redirect address width
//     INST_W     instruction width (RV32I, 32)
//     FLUSH_CYC  cycles ifq_rd_en is held low after a redirect (1..7)
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     ifq_empty/pc/inst   in    IFQ head (valid when !ifq_empty)
//     ifq_rd_en           out   pops the IFQ head at this edge (combinational)
//     jmp_branch_address  out   redirect target to the IFQ
//     jmp_branch_valid    out   one-cycle redirect pulse to the IFQ
//     ex_redirect_valid   in    execute-stage redirect request
//     ex_redirect_addr    in    execute-stage redirect target
//     dec_valid/ready           output slot handshake
//     dec_pc, dec_inst    out   pass-through of the popped entry
//     dec_opclass         out   decoded class (opclass_t)
//     dec_rd/rs1/rs2      out   register fields (0 when unused)
//     dec_imm             out   sign-extended immediate
//     fsm_state           out   RUN(0)/FLUSH(1) state, for observation
//     stat_issued         out   handshakes            (stats build only)
//     stat_jal_redirects  out   JAL redirects         (stats build only)
//     stat_ex_redirects   out   execute redirects     (stats build only)
//     stat_stall_cycles   out   dec_valid && !ready   (stats build only)
// ----------------------------------------------------------------------------
module dispatch_decode
    import fetch_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int FLUSH_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifq_empty,
    input  logic [PC_W-1:0]   ifq_pc,
    input  logic [INST_W-1:0] ifq_inst,
    output logic              ifq_rd_en,
    output logic [PC_W-1:0]   jmp_branch_address,
    output logic              jmp_branch_valid,
    input  logic              ex_redirect_valid,
    input  logic [PC_W-1:0]   ex_redirect_addr,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [PC_W-1:0]   dec_pc,
    output logic [INST_W-1:0] dec_inst,
    output logic [3:0]        dec_opclass,
    output logic [4:0]        dec_rd,
    output logic [4:0]        dec_rs1,
    output logic [4:0]        dec_rs2,
    output logic [31:0]       dec_imm,
    output logic              fsm_state
`ifdef DISPATCH_DECODE_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [15:0]       stat_jal_redirects,
    output logic [15:0]       stat_ex_redirects,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);

    logic [0:0]  state;
    logic [2:0]  flush_cnt;
    dec_fields_t fields;
    logic        jal_pop;
    logic        handshake;

    // Combinational decode of the IFQ head, so the slot can load the decoded
    // fields on the same edge that pops the entry.
    rv32_decoder u_decoder (
        .inst    (ifq_inst),
        .opclass (fields.opclass),
        .rd      (fields.rd),
        .rs1     (fields.rs1),
        .rs2     (fields.rs2),
        .imm     (fields.imm)
    );

    // Handshake: the slot transfers to dispatch on an edge where dec_valid and
    // dec_ready are both high. While dec_valid is high and dec_ready is low,
    // every dec_* output holds. A new entry may be popped on the same edge as
    // the outgoing handshake, giving one instruction per cycle.
    assign handshake = dec_valid && dec_ready;

    // An execute redirect blocks the pop so a JAL racing it is left in the IFQ.
    assign ifq_rd_en = !rst && (state == ST_RUN) && !ifq_empty &&
                       !ex_redirect_valid && (!dec_valid || dec_ready);

    assign jal_pop   = ifq_rd_en && (fields.opclass == OC_JAL);
    assign fsm_state = state;

    // Output slot. The squash from an execute redirect beats both the pop
    // (already blocked above) and the handshake clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid   <= 1'b0;
            dec_pc      <= '0;
            dec_inst    <= '0;
            dec_opclass <= OC_ILLEGAL;
            dec_rd      <= 5'd0;
            dec_rs1     <= 5'd0;
            dec_rs2     <= 5'd0;
            dec_imm     <= 32'd0;
        end else if (ex_redirect_valid) begin
            dec_valid <= 1'b0;
        end else if (ifq_rd_en) begin
            dec_valid   <= 1'b1;
            dec_pc      <= ifq_pc;
            dec_inst    <= ifq_inst;
            dec_opclass <= fields.opclass;
            dec_rd      <= fields.rd;
            dec_rs1     <= fields.rs1;
            dec_rs2     <= fields.rs2;
            dec_imm     <= fields.imm;
        end else if (handshake) begin
            dec_valid <= 1'b0;
        end
    end

    // Redirect port: registered address, single-cycle pulse the cycle after
    // the causing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            jmp_branch_valid   <= 1'b0;
            jmp_branch_address <= '0;
        end else begin
            jmp_branch_valid <= ex_redirect_valid || jal_pop;
            if (ex_redirect_valid) begin
                jmp_branch_address <= ex_redirect_addr;
            end else if (jal_pop) begin
                jmp_branch_address <= ifq_pc + PC_W'(fields.imm);
            end
        end
    end

    // RUN/FLUSH sequencing. Every redirect (re)loads the counter, so the pop
    // stays blocked for FLUSH_CYC cycles counted from the latest redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else if (ex_redirect_valid || jal_pop) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
        end else if (state == ST_FLUSH) begin
            if (flush_cnt <= 3'd1) begin
                state     <= ST_RUN;
                flush_cnt <= 3'd0;
            end else begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

`ifdef DISPATCH_DECODE_STATS_EN
    // Free-running wrapping counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued        <= 32'd0;
            stat_jal_redirects <= 16'd0;
            stat_ex_redirects  <= 16'd0;
            stat_stall_cycles  <= 32'd0;
        end else begin
            if (handshake) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (jal_pop) begin
                stat_jal_redirects <= stat_jal_redirects + 16'd1;
            end
            if (ex_redirect_valid) begin
                stat_ex_redirects <= stat_ex_redirects + 16'd1;
            end
            if (dec_valid && !dec_ready) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_decode.sv
// ----------------------------------------------------------------------------
// tb_dispatch_decode
//   Self-checking bench for dispatch_decode (default build, FLUSH_CYC = 2).
//   Directed scenario tasks followed by a randomized run checked against a
//   cycle-level behavioural model of the decode stage.
// ----------------------------------------------------------------------------
module tb_dispatch_decode;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int FC     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifq_empty;
    logic [PC_W-1:0]   ifq_pc;
    logic [INST_W-1:0] ifq_inst;
    logic              ifq_rd_en;
    logic [PC_W-1:0]   jmp_branch_address;
    logic              jmp_branch_valid;
    logic              ex_redirect_valid;
    logic [PC_W-1:0]   ex_redirect_addr;
    logic              dec_valid;
    logic              dec_ready;
    logic [PC_W-1:0]   dec_pc;
    logic [INST_W-1:0] dec_inst;
    logic [3:0]        dec_opclass;
    logic [4:0]        dec_rd;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [31:0]       dec_imm;
    logic              fsm_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dispatch_decode #(
        .PC_W      (PC_W),
        .INST_W    (INST_W),
        .FLUSH_CYC (FC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ifq_empty          (ifq_empty),
        .ifq_pc             (ifq_pc),
        .ifq_inst           (ifq_inst),
        .ifq_rd_en          (ifq_rd_en),
        .jmp_branch_address (jmp_branch_address),
        .jmp_branch_valid   (jmp_branch_valid),
        .ex_redirect_valid  (ex_redirect_valid),
        .ex_redirect_addr   (ex_redirect_addr),
        .dec_valid          (dec_valid),
        .dec_ready          (dec_ready),
        .dec_pc             (dec_pc),
        .dec_inst           (dec_inst),
        .dec_opclass        (dec_opclass),
        .dec_rd             (dec_rd),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_imm            (dec_imm),
        .fsm_state          (fsm_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifq_empty         = 1'b1;
        ifq_pc            = '0;
        ifq_inst          = '0;
        ex_redirect_valid = 1'b0;
        ex_redirect_addr  = '0;
        dec_ready         = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model helpers ----------------
    // Decode straight from the RV32I encoding tables using integer arithmetic.
    function automatic void ref_decode(input logic [31:0] inst, output logic [3:0] oc,
                                       output logic [4:0] rd, output logic [4:0] rs1,
                                       output logic [4:0] rs2, output logic [31:0] imm);
        int v;
        v = 0; oc = 4'd15; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
        case (inst[6:0])
            7'b0110011: begin oc = 4'd0; rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                oc = (inst[6:0] == 7'b0010011) ? 4'd1 : (inst[6:0] == 7'b0000011) ? 4'd2 : 4'd6;
                rd = inst[11:7]; rs1 = inst[19:15];
                v = int'(inst[31:20]);
                if (v >= 2048) v = v - 4096;
                imm = v;
            end
            7'b0100011: begin
                oc = 4'd3; rs1 = inst[19:15]; rs2 = inst[24:20];
                v = int'(inst[31:25]) * 32 + int'(inst[11:7]);
                if (v >= 2048) v = v - 4096;
                imm = v;
            end
            7'b1100011: begin
                oc = 4'd4; rs1 = inst[19:15]; rs2 = inst[24:20];
                v = int'(inst[31]) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
                imm = v;
            end
            7'b0110111: begin oc = 4'd7; rd = inst[11:7]; imm = {inst[31:12], 12'h000}; end
            7'b0010111: begin oc = 4'd8; rd = inst[11:7]; imm = {inst[31:12], 12'h000}; end
            7'b1101111: begin
                oc = 4'd5; rd = inst[11:7];
                v = int'(inst[31]) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
                imm = v;
            end
            default: oc = 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] random_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            6: op = 7'b1100111;
            7: op = 7'b0110111;
            8: op = 7'b0010111;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        ifq_empty = 1'b0;
        ifq_pc    = 32'h40;
        ifq_inst  = 32'h00500093;
        tick();
        tick();
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b exp 0", ifq_rd_en); end
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
        n_vec++; if ({dec_pc, dec_inst, dec_imm} !== 96'd0) begin n_err++; $display("FAIL reset_slot pc %h inst %h imm %h exp 0", dec_pc, dec_inst, dec_imm); end
        n_vec++; if (dec_opclass !== 4'd15) begin n_err++; $display("FAIL reset_opclass got %0d exp 15", dec_opclass); end
        n_vec++; if ({dec_rd, dec_rs1, dec_rs2} !== 15'd0) begin n_err++; $display("FAIL reset_regs got %h exp 0", {dec_rd, dec_rs1, dec_rs2}); end
        n_vec++; if ({jmp_branch_valid, jmp_branch_address} !== 33'd0) begin n_err++; $display("FAIL reset_jmp got %b/%h exp 0/0", jmp_branch_valid, jmp_branch_address); end
        n_vec++; if (fsm_state !== 1'b0) begin n_err++; $display("FAIL reset_state got %b exp RUN(0)", fsm_state); end
        tick();
        rst = 1'b0;
        ifq_empty = 1'b1;
    endtask

    task automatic test_addi();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'h0; ifq_inst = 32'h00500093; dec_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL addi_pop got %b exp 1", ifq_rd_en); end
        tick();
        ifq_empty = 1'b1;
        @(negedge clk);
        n_vec++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b exp 1", dec_valid); end
        n_vec++; if (dec_opclass !== 4'd1) begin n_err++; $display("FAIL addi_opclass got %0d exp 1", dec_opclass); end
        n_vec++; if ({dec_rd, dec_rs1, dec_rs2} !== {5'd1, 5'd0, 5'd0}) begin n_err++; $display("FAIL addi_regs got %0d/%0d/%0d exp 1/0/0", dec_rd, dec_rs1, dec_rs2); end
        n_vec++; if (dec_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm got %h exp 5", dec_imm); end
        n_vec++; if ({dec_pc, dec_inst} !== {32'h0, 32'h00500093}) begin n_err++; $display("FAIL addi_pass pc %h inst %h", dec_pc, dec_inst); end
        tick();
        @(negedge clk);
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got %b exp 0", dec_valid); end
    endtask

    task automatic test_jal();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'h100; ifq_inst = 32'h0200006F; dec_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL jal_pop got %b exp 1", ifq_rd_en); end
        tick();
        ifq_pc = 32'h104; ifq_inst = 32'h00A00113;
        @(negedge clk);
        n_vec++; if (jmp_branch_valid !== 1'b1) begin n_err++; $display("FAIL jal_pulse got %b exp 1", jmp_branch_valid); end
        n_vec++; if (jmp_branch_address !== 32'h120) begin n_err++; $display("FAIL jal_target got %h exp 120", jmp_branch_address); end
        n_vec++; if ({dec_valid, dec_opclass, dec_rd} !== {1'b1, 4'd5, 5'd0}) begin n_err++; $display("FAIL jal_slot valid %b oc %0d rd %0d", dec_valid, dec_opclass, dec_rd); end
        n_vec++; if (dec_imm !== 32'h20) begin n_err++; $display("FAIL jal_imm got %h exp 20", dec_imm); end
        n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL jal_flush0 got %b exp 0", ifq_rd_en); end
        for (int i = 1; i < FC; i++) begin
            tick();
            @(negedge clk);
            n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL jal_flush%0d got %b exp 0", i, ifq_rd_en); end
            n_vec++; if (jmp_branch_valid !== 1'b0) begin n_err++; $display("FAIL jal_pulse_len got %b exp 0", jmp_branch_valid); end
        end
        tick();
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL jal_resume got %b exp 1", ifq_rd_en); end
        ifq_empty = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'h200; ifq_inst = 32'h00500093; dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0; ifq_pc = 32'h204; ifq_inst = 32'h00A00113;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL stall_pop%0d got %b exp 0", i, ifq_rd_en); end
            n_vec++; if ({dec_valid, dec_pc, dec_inst, dec_imm} !== {1'b1, 32'h200, 32'h00500093, 32'd5}) begin
                n_err++; $display("FAIL stall_hold%0d valid %b pc %h inst %h imm %h", i, dec_valid, dec_pc, dec_inst, dec_imm);
            end
            tick();
        end
        dec_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL stall_release_pop got %b exp 1", ifq_rd_en); end
        tick();
        ifq_empty = 1'b1;
        @(negedge clk);
        n_vec++; if ({dec_valid, dec_pc, dec_rd, dec_imm} !== {1'b1, 32'h204, 5'd2, 32'd10}) begin
            n_err++; $display("FAIL stall_next valid %b pc %h rd %0d imm %h exp 1/204/2/a", dec_valid, dec_pc, dec_rd, dec_imm);
        end
        tick();
    endtask

    task automatic test_jal_vs_ex();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'h2F0; ifq_inst = 32'h00500093; dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0; ifq_pc = 32'h300; ifq_inst = 32'h0200006F;
        ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h400;
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL race_pop got %b exp 0", ifq_rd_en); end
        tick();
        ex_redirect_valid = 1'b0; ifq_empty = 1'b1;
        @(negedge clk);
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL race_squash got %b exp 0", dec_valid); end
        n_vec++; if ({jmp_branch_valid, jmp_branch_address} !== {1'b1, 32'h400}) begin
            n_err++; $display("FAIL race_pulse got %b/%h exp 1/400", jmp_branch_valid, jmp_branch_address);
        end
        tick();
        @(negedge clk);
        n_vec++; if (jmp_branch_valid !== 1'b0) begin n_err++; $display("FAIL race_pulse_len got %b exp 0", jmp_branch_valid); end
        dec_ready = 1'b1;
        tick();
    endtask

    task automatic test_ex_in_flush();
        do_reset();
        ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h500;
        tick();
        ex_redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if ({jmp_branch_valid, jmp_branch_address} !== {1'b1, 32'h500}) begin
            n_err++; $display("FAIL flush_first got %b/%h exp 1/500", jmp_branch_valid, jmp_branch_address);
        end
        tick();
        ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h800;
        ifq_empty = 1'b0; ifq_pc = 32'h800; ifq_inst = 32'h00500093; dec_ready = 1'b1;
        @(negedge clk);
        n_vec++; if ({ifq_rd_en, jmp_branch_valid} !== 2'b00) begin n_err++; $display("FAIL flush_mid rd_en %b pulse %b exp 0/0", ifq_rd_en, jmp_branch_valid); end
        tick();
        ex_redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if ({jmp_branch_valid, jmp_branch_address} !== {1'b1, 32'h800}) begin
            n_err++; $display("FAIL flush_second got %b/%h exp 1/800", jmp_branch_valid, jmp_branch_address);
        end
        n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL flush_reload0 got %b exp 0", ifq_rd_en); end
        for (int i = 1; i < FC; i++) begin
            tick();
            @(negedge clk);
            n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL flush_reload%0d got %b exp 0", i, ifq_rd_en); end
        end
        tick();
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL flush_resume got %b exp 1", ifq_rd_en); end
        ifq_empty = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'h600; ifq_inst = 32'hFFFFFFFF; dec_ready = 1'b1;
        tick();
        ifq_pc = 32'h604; ifq_inst = 32'h00000000;
        @(negedge clk);
        n_vec++; if ({dec_valid, dec_opclass, dec_inst} !== {1'b1, 4'd15, 32'hFFFFFFFF}) begin
            n_err++; $display("FAIL illegal_slot valid %b oc %0d inst %h", dec_valid, dec_opclass, dec_inst);
        end
        n_vec++; if ({dec_rd, dec_rs1, dec_rs2, dec_imm} !== 47'd0) begin n_err++; $display("FAIL illegal_fields regs %h imm %h exp 0", {dec_rd, dec_rs1, dec_rs2}, dec_imm); end
        n_vec++; if ({jmp_branch_valid, ifq_rd_en} !== 2'b01) begin n_err++; $display("FAIL illegal_noredirect pulse %b rd_en %b exp 0/1", jmp_branch_valid, ifq_rd_en); end
        tick();
        ifq_empty = 1'b1;
        @(negedge clk);
        n_vec++; if ({dec_valid, dec_opclass, dec_pc} !== {1'b1, 4'd15, 32'h604}) begin
            n_err++; $display("FAIL illegal_zero valid %b oc %0d pc %h", dec_valid, dec_opclass, dec_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.delete();
        dec_ready = 1'b1;
        ifq_empty = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifq_pc   = 32'h1000 + 32'(i * 4);
            ifq_inst = 32'h00500093;
            @(negedge clk);
            n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL b2b_pop%0d got %b exp 1", i, ifq_rd_en); end
            if (i > 0) begin
                n_vec++; if ({dec_valid, dec_pc} !== {1'b1, exp_q[0]}) begin
                    n_err++; $display("FAIL b2b_out%0d got %b/%h exp 1/%h", i, dec_valid, dec_pc, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            exp_q.push_back(ifq_pc);
            tick();
        end
        ifq_empty = 1'b1;
        @(negedge clk);
        n_vec++; if ({dec_valid, dec_pc} !== {1'b1, exp_q[0]}) begin n_err++; $display("FAIL b2b_last got %b/%h exp 1/%h", dec_valid, dec_pc, exp_q[0]); end
        void'(exp_q.pop_front());
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifq_empty = 1'b0; ifq_pc = 32'hA00; ifq_inst = 32'h00500093; dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (ifq_rd_en !== 1'b0) begin n_err++; $display("FAIL rstmid_rd_en got %b exp 0", ifq_rd_en); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if ({dec_valid, ifq_rd_en} !== 2'b01) begin n_err++; $display("FAIL rstmid_stall valid %b rd_en %b exp 0/1", dec_valid, ifq_rd_en); end
        ifq_empty = 1'b1; dec_ready = 1'b1;
        ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h900;
        tick();
        ex_redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifq_empty = 1'b0;
        @(negedge clk);
        n_vec++; if ({jmp_branch_valid, jmp_branch_address} !== 33'd0) begin n_err++; $display("FAIL rstmid_pulse got %b/%h exp 0/0", jmp_branch_valid, jmp_branch_address); end
        n_vec++; if (ifq_rd_en !== 1'b1) begin n_err++; $display("FAIL rstmid_flush got %b exp 1", ifq_rd_en); end
        ifq_empty = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        m_valid;
        logic [31:0] m_pc;
        logic [31:0] m_inst;
        logic        m_pulse;
        logic [31:0] m_addr;
        int          flush_left;
        logic        exp_rd;
        logic [31:0] head_pc;
        logic [31:0] head_inst;
        logic [31:0] r;
        logic [3:0]  e_oc;
        logic [4:0]  e_rd;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [31:0] e_imm;

        do_reset();
        m_valid = 1'b0; m_pc = '0; m_inst = '0; m_pulse = 1'b0; m_addr = '0; flush_left = 0;
        head_pc = 32'h2000; head_inst = random_inst();
        for (int c = 0; c < 600; c++) begin
            dec_ready         = ($urandom_range(0, 3) != 0);
            ex_redirect_valid = ($urandom_range(0, 19) == 0);
            r                 = $urandom;
            ex_redirect_addr  = r & 32'hFFFF_FFFE;
            ifq_empty         = ($urandom_range(0, 4) == 0);
            ifq_pc            = head_pc;
            ifq_inst          = head_inst;
            @(negedge clk);
            exp_rd = (flush_left == 0) && !ifq_empty && !ex_redirect_valid && (!m_valid || dec_ready);
            n_vec++; if (ifq_rd_en !== exp_rd) begin n_err++; $display("FAIL rnd_rd_en cyc %0d got %b exp %b", c, ifq_rd_en, exp_rd); end
            n_vec++; if (dec_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, dec_valid, m_valid); end
            n_vec++; if (jmp_branch_valid !== m_pulse) begin n_err++; $display("FAIL rnd_pulse cyc %0d got %b exp %b", c, jmp_branch_valid, m_pulse); end
            if (m_pulse) begin
                n_vec++; if (jmp_branch_address !== m_addr) begin n_err++; $display("FAIL rnd_target cyc %0d got %h exp %h", c, jmp_branch_address, m_addr); end
            end
            if (m_valid) begin
                ref_decode(m_inst, e_oc, e_rd, e_rs1, e_rs2, e_imm);
                n_vec++; if ({dec_pc, dec_inst} !== {m_pc, m_inst}) begin n_err++; $display("FAIL rnd_pass cyc %0d got %h/%h exp %h/%h", c, dec_pc, dec_inst, m_pc, m_inst); end
                n_vec++; if ({dec_opclass, dec_rd, dec_rs1, dec_rs2} !== {e_oc, e_rd, e_rs1, e_rs2}) begin
                    n_err++; $display("FAIL rnd_fields cyc %0d inst %h got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", c, m_inst,
                                      dec_opclass, dec_rd, dec_rs1, dec_rs2, e_oc, e_rd, e_rs1, e_rs2);
                end
                n_vec++; if (dec_imm !== e_imm) begin n_err++; $display("FAIL rnd_imm cyc %0d inst %h got %h exp %h", c, m_inst, dec_imm, e_imm); end
            end
            // Advance the model across the coming edge.
            if (ex_redirect_valid) begin
                m_valid = 1'b0; m_pulse = 1'b1; m_addr = ex_redirect_addr; flush_left = FC;
            end else if (exp_rd) begin
                m_valid = 1'b1; m_pc = ifq_pc; m_inst = ifq_inst;
                ref_decode(ifq_inst, e_oc, e_rd, e_rs1, e_rs2, e_imm);
                if (e_oc == 4'd5) begin
                    m_pulse = 1'b1; m_addr = ifq_pc + e_imm; flush_left = FC;
                end else begin
                    m_pulse = 1'b0;
                end
            end else begin
                if (m_valid && dec_ready) m_valid = 1'b0;
                m_pulse = 1'b0;
                if (flush_left > 0) flush_left = flush_left - 1;
            end
            tick();
            if (exp_rd) begin
                head_pc   = head_pc + 32'd4;
                head_inst = random_inst();
            end
        end
        drive_idle();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_addi();
        test_jal();
        test_stall();
        test_jal_vs_ex();
        test_ex_in_flush();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_decode.md
# dispatch_decode

Front-end decode stage sitting directly downstream of the instruction fetch queue (IFQ) and upstream of dispatch. Pops one instruction per cycle from the IFQ head, decodes RV32I fields into a registered valid/ready output slot, resolves JAL targets locally, and drives the IFQ jump/branch redirect port. It also forwards execute-stage redirects, and squashes wrong-path work during a short flush window.

## Interface
- PC_W, 32, PC and redirect address width
- INST_W, 32, instruction width (RV32I only)
- FLUSH_CYC, 1, cycles `ifq_rd_en` stays low after any redirect (range 1–7)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ifq_empty  in  1  IFQ has no head entry
- ifq_pc  in  PC_W  PC of IFQ head, valid when !ifq_empty
- ifq_inst  in  INST_W  instruction at IFQ head, valid when !ifq_empty
- ifq_rd_en  out  1  pops the IFQ head at this edge
- jmp_branch_address  out  PC_W  redirect target to IFQ
- jmp_branch_valid  out  1  one-cycle redirect pulse to IFQ
- ex_redirect_valid  in  1  execute-stage mispredict or JALR redirect
- ex_redirect_addr  in  PC_W  execute redirect target
- dec_valid  out  1  output slot holds an instruction
- dec_ready  in  1  dispatch accepts the slot this edge
- dec_pc, dec_inst  out  PC_W / INST_W  pass-through of the popped entry
- dec_opclass  out  4  decoded class (see Structure)
- dec_rd, dec_rs1, dec_rs2  out  5 each  register fields; zeroed when unused by the format
- dec_imm  out  32  sign-extended immediate for the format; 0 for R-type

## Operation
- IFQ head is first-word-fall-through. `ifq_rd_en` is combinational:
  - `ifq_rd_en = state==RUN && !ifq_empty && !ex_redirect_valid && (!dec_valid || dec_ready)`.
- On a pop, the slot loads pc, inst, and decoded fields, and `dec_valid` is set. If there is a handshake (`dec_valid && dec_ready`) with no pop, `dec_valid` clears.
- JAL pop:
  - Slot loads the JAL normally, because dispatch needs it for the rd link.
  - Registered `jmp_branch_address` is set to `ifq_pc + imm_J` (mod 2^PC_W).
  - `jmp_branch_valid` pulses next cycle and the FSM enters FLUSH.
- JALR and conditional branches pass through unresolved. Execute redirects for them.
- Execute redirect (highest priority):
  - On an edge with `ex_redirect_valid`, `dec_valid` is cleared (squash) with no pop.
  - `jmp_branch_address` is set to `ex_redirect_addr`, `jmp_branch_valid` pulses next cycle, and the FSM enters FLUSH.
- FSM RUN/FLUSH:
  - FLUSH loads counter = FLUSH_CYC and decrements each cycle. It returns to RUN when the counter hits 0.
  - A new `ex_redirect_valid` during FLUSH reloads the counter and issues a new pulse with the new address.
- Illegal or unknown opcode: opclass ILLEGAL, all fields 0, still delivered. There is no redirect.

## Timing
- Reset values: dec_valid 0; dec_pc, dec_inst, dec_imm, jmp_branch_address 0; dec_opclass ILLEGAL; reg fields 0; jmp_branch_valid 0; state RUN.
- `ifq_rd_en` is 0 while `rst` is high.
- Decode latency: 1 cycle (pop edge to dec_valid).
- Redirect pulse: exactly 1 cycle, starting the cycle after the causing edge.
- JAL and `ex_redirect_valid` on the same edge: the execute redirect wins and the JAL is not popped.
- Stall: with dec_ready=0 and dec_valid=1, all dec_* outputs are held stable and no pop occurs.
- Empty: dec_valid drops after the handshake, and no pop occurs.
- Reset mid-flush or mid-stall drops the slot and any pending pulse.
- Back-to-back throughput: 1 instruction per cycle when dec_ready is held high.

## Configuration
- DISPATCH_DECODE_STATS_EN defined adds the following output ports, all wrapping and reset to 0:
  - stat_issued (32): counts handshakes.
  - stat_jal_redirects (16)
  - stat_ex_redirects (16)
  - stat_stall_cycles (32): counts cycles with `dec_valid && !dec_ready`.
- Undefined: these ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - opclass enum: ALU=0, ALUI=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, ILLEGAL=15.
  - RV32I opcode constants.
  - Decoded-instruction struct.
- Sub-module `rv32_decoder`: purely combinational inst → opclass, regs, imm, reused later by dispatch. The top module holds the slot, FSM, redirect registers, and counters.

## Test plan
- Reset with ifq_empty=0 → ifq_rd_en=0 while rst=1; all outputs at their reset values.
- Head pc 0x0, inst 0x00500093 (addi x1,x0,5), dec_ready=1 → next cycle: dec_valid=1, opclass ALUI, rd=1, rs1=0, imm=5.
- Head pc 0x100, inst 0x0200006F (jal x0,0x20) → jmp_branch_valid for 1 cycle with address 0x120; ifq_rd_en=0 for FLUSH_CYC cycles; JAL is delivered with opclass JAL.
- dec_ready=0 for 3 cycles with a full slot and a non-empty IFQ → no pops; dec_* stable; after release, the next pop happens the same cycle as the handshake.
- JAL at head and ex_redirect_valid=1 (addr 0x400) on the same edge → no pop; slot squashed; pulse carries 0x400.
- A second ex_redirect (0x800) during FLUSH → counter restarts and a second pulse carries 0x800.
